i2c_master_arbiter: RTL

- Shares one i2c_master command/data interface between N_REQ client blocks (sensor pollers, config loaders) using round-robin arbitration.
- Latches the winner's command, issues the start to the master, and routes TX/RX streams and completion status to the granted client only.
- Holds the grant until the master pulses transfer-done.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/i2c_master_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C master arbiter slice:
//   - arbiter FSM state encoding (ST_ARB_IDLE / ST_ARB_ISSUE / ST_ARB_BUSY)
//   - command / data field widths (ADDR_W, NBYTES_W, DATA_W)
//   - clog2 helper used to size index and counter vectors at elaboration
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int ADDR_W   = 7;
  localparam int NBYTES_W = 3;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    ST_ARB_IDLE  = 2'd0,
    ST_ARB_ISSUE = 2'd1,
    ST_ARB_BUSY  = 2'd2
  } arb_state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority arbiter. The search for a set
// request bit starts at index ptr and wraps modulo N, so the client at ptr
// has the highest priority and the one just below it the lowest.
//
// Ports:
//   req       in  [N-1:0]      request vector
//   ptr       in  [IDX_W-1:0]  highest-priority index (must be < N)
//   grant     out [N-1:0]      one-hot grant (zero when no request)
//   grant_idx out [IDX_W-1:0]  binary index of the granted request
//   any_req   out              at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
  import i2c_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  // cand_idx[i] is the client examined at priority position i.
  logic [IDX_W-1:0] cand_idx [N];
  logic [N-1:0]     cand_req;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign cand_idx[gi] = IDX_W'((int'(ptr) + gi) % N);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from lowest priority up so the last hit (highest priority) wins.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_idx = cand_idx[i];
        any_req   = 1'b1;
      end
    end
    grant = any_req ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
// Shares one i2c_master command/data interface between N_REQ clients with
// round-robin arbitration. The winner's command is latched, the start is
// issued to the master, TX/RX streams and completion status are routed to
// the granted client only, and the grant is held until the master reports
// transfer-done.
//
// Optional feature: define I2C_ARB_WATCHDOG_EN to build a BUSY watchdog
// that aborts the master after TIMEOUT_CYCLES cycles without m_done and
// reports the transfer as failed. Without the macro m_abort is tied low.
//
// Ports (client side, client k occupies slice k of each packed bus):
//   clk, rst      clock, asynchronous active-high reset
//   i_req         per-client request (level)
//   i_addr        packed 7-bit addresses
//   i_n_bytes     packed 3-bit byte counts
//   i_is_read     per-client direction (1 = read)
//   o_accept      one-hot pulse: command latched
//   i_tx_valid    per-client TX valid      i_tx_data  packed TX bytes
//   o_tx_ready    TX ready, granted client only
//   o_rx_valid    RX valid, granted client only
//   o_rx_data     RX byte, broadcast       i_rx_ready per-client RX ready
//   o_done        one-hot pulse: transfer finished
//   o_ack_err     qualifies o_done; 1 = NACK or timeout
//   o_busy        arbiter not idle
// Ports (master side):
//   m_start, m_addr, m_n_bytes, m_is_read   command to master
//   m_ready_for_cmd                         master idle
//   m_tx_valid, m_tx_data / m_tx_ready      TX stream
//   m_rx_valid, m_rx_data / m_rx_ready      RX stream
//   m_done, m_ack_err                       completion
//   m_abort                                 1-cycle master reset (watchdog)
// ---------------------------------------------------------------------------
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int IDX_W         = clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [ADDR_W*N_REQ-1:0]   i_addr,
  input  logic [NBYTES_W*N_REQ-1:0] i_n_bytes,
  input  logic [N_REQ-1:0]          i_is_read,
  output logic [N_REQ-1:0]          o_accept,
  input  logic [N_REQ-1:0]          i_tx_valid,
  input  logic [DATA_W*N_REQ-1:0]   i_tx_data,
  output logic [N_REQ-1:0]          o_tx_ready,
  output logic [N_REQ-1:0]          o_rx_valid,
  output logic [DATA_W-1:0]         o_rx_data,
  input  logic [N_REQ-1:0]          i_rx_ready,
  output logic [N_REQ-1:0]          o_done,
  output logic [N_REQ-1:0]          o_ack_err,
  output logic                      o_busy,
  output logic                      m_start,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [NBYTES_W-1:0]       m_n_bytes,
  output logic                      m_is_read,
  input  logic                      m_ready_for_cmd,
  output logic                      m_tx_valid,
  output logic [DATA_W-1:0]         m_tx_data,
  input  logic                      m_tx_ready,
  input  logic                      m_rx_valid,
  input  logic [DATA_W-1:0]         m_rx_data,
  output logic                      m_rx_ready,
  input  logic                      m_done,
  input  logic                      m_ack_err,
  output logic                      m_abort
);

  arb_state_t state_reg, state_next;

  logic [IDX_W-1:0]    ptr_reg;
  logic [IDX_W-1:0]    g_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [NBYTES_W-1:0] nbytes_reg;
  logic                is_read_reg;
  logic [N_REQ-1:0]    accept_reg;
  logic [N_REQ-1:0]    done_reg;
  logic [N_REQ-1:0]    ack_err_reg;

  logic [N_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  logic                timeout;
  logic                finish;
  logic                active;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req       (i_req),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

`ifdef I2C_ARB_WATCHDOG_EN
  localparam int WD_W = clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            abort_reg;

  // Counter holds the number of BUSY cycles already spent; it is zero in
  // the first BUSY cycle, so the timeout fires in the cycle where the count
  // would reach TIMEOUT_CYCLES. m_done in that cycle wins.
  assign timeout = (state_reg == ST_ARB_BUSY) && !m_done &&
                   (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg <= '0;
      abort_reg  <= 1'b0;
    end else begin
      abort_reg <= timeout;
      if (state_reg != ST_ARB_BUSY) begin
        wd_cnt_reg <= '0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
    end
  end

  assign m_abort = abort_reg;
`else
  assign timeout = 1'b0;
  assign m_abort = 1'b0;
`endif

  assign finish = (state_reg == ST_ARB_BUSY) && (m_done || timeout);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ARB_IDLE:  if (arb_any) state_next = ST_ARB_ISSUE;
      ST_ARB_ISSUE: if (m_ready_for_cmd) state_next = ST_ARB_BUSY;
      ST_ARB_BUSY:  if (m_done || timeout) state_next = ST_ARB_IDLE;
      default:      state_next = ST_ARB_IDLE;
    endcase
  end

  // Latched command, grant, pointer and the registered client pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg     <= '0;
      g_reg       <= '0;
      addr_reg    <= '0;
      nbytes_reg  <= '0;
      is_read_reg <= 1'b0;
      accept_reg  <= '0;
      done_reg    <= '0;
      ack_err_reg <= '0;
    end else begin
      accept_reg  <= '0;
      done_reg    <= '0;
      ack_err_reg <= '0;
      if (state_reg == ST_ARB_IDLE && arb_any) begin
        g_reg       <= arb_idx;
        accept_reg  <= arb_grant;
        addr_reg    <= i_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        nbytes_reg  <= i_n_bytes[int'(arb_idx)*NBYTES_W +: NBYTES_W];
        is_read_reg <= i_is_read[arb_idx];
      end
      if (finish) begin
        done_reg <= N_REQ'(1) << g_reg;
        // A timeout always reports an error; otherwise the master's status.
        ack_err_reg <= (m_done && !m_ack_err) ? '0 : (N_REQ'(1) << g_reg);
        ptr_reg <= (int'(g_reg) == N_REQ - 1) ? '0 : g_reg + 1'b1;
      end
    end
  end

  assign o_accept  = accept_reg;
  assign o_done    = done_reg;
  assign o_ack_err = ack_err_reg;
  assign m_addr    = addr_reg;
  assign m_n_bytes = nbytes_reg;
  assign m_is_read = is_read_reg;

  // Output logic: start strobe and stream routing to the granted client.
  always_comb begin
    active     = (state_reg != ST_ARB_IDLE);
    o_busy     = active;
    m_start    = (state_reg == ST_ARB_ISSUE) && m_ready_for_cmd;
    m_tx_valid = 1'b0;
    m_tx_data  = '0;
    m_rx_ready = 1'b0;
    o_rx_data  = '0;
    o_tx_ready = '0;
    o_rx_valid = '0;
    if (active) begin
      m_tx_valid        = i_tx_valid[g_reg];
      m_tx_data         = i_tx_data[int'(g_reg)*DATA_W +: DATA_W];
      m_rx_ready        = i_rx_ready[g_reg];
      o_rx_data         = m_rx_data;
      o_tx_ready[g_reg] = m_tx_ready;
      o_rx_valid[g_reg] = m_rx_valid;
    end
  end

endmodule
